// File: rtl/zuart_pkg.sv
// Shared UART constants and the receiver state encoding.
// The transmitter imports the frame constants from this package as well.
package zuart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
   localparam int unsigned DATA_BITS            = 8;
   localparam logic        MARK_LEVEL           = 1'b1;
   localparam logic        STOP_LEVEL           = 1'b1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_MARK,
      RX_STOP,
      RX_RESULT,
      RX_WAIT_HIGH
   } rx_state_t;

endpackage

// File: rtl/zuart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input that idles high.
module zuart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/zuart_module_rx.sv
// UART receiver: start, 8 data bits LSB first, optional mark bit, stop.
// Mid-bit sampling from an internal baud counter; done / frame_err pulses.
module zuart_module_rx
   import zuart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,  // must be >= 4
   parameter int unsigned EXTRA_BIT    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 rx_pin,
   output logic [DATA_BITS-1:0] data,
   output logic                 done,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);
   localparam int unsigned HALF      = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);

   rx_state_t state, next_state;

   logic                 rx_s;
   logic [CNT_W-1:0]     cnt;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 err;
   logic                 stop_low;
   logic                 timed;
   logic                 sample;

   logic [DATA_BITS-1:0] data_nxt;
   logic                 done_nxt;
   logic                 frame_err_nxt;
   logic                 busy_nxt;

   zuart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_pin),
      .q   (rx_s)
   );

   // Start is checked half a bit after detection (detection cycle is t=0, START entry is t=1).
   always_comb begin
      timed  = (state == RX_START) || (state == RX_DATA) ||
               (state == RX_MARK)  || (state == RX_STOP);
      sample = 1'b0;
      if (state == RX_START) begin
         sample = (cnt == HALF_LAST);
      end else if (timed) begin
         sample = (cnt == BIT_LAST);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RX_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (!en) begin
         next_state = RX_IDLE;
      end else begin
         case (state)
            RX_IDLE:      if (!rx_s) next_state = RX_START;
            RX_START:     if (sample) next_state = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:      if (sample && (bit_cnt == LAST_BIT))
                             next_state = (EXTRA_BIT != 0) ? RX_MARK : RX_STOP;
            RX_MARK:      if (sample) next_state = RX_STOP;
            RX_STOP:      if (sample) next_state = RX_RESULT;
            RX_RESULT:    next_state = stop_low ? RX_WAIT_HIGH : RX_IDLE;
            RX_WAIT_HIGH: if (rx_s) next_state = RX_IDLE;
            default:      next_state = RX_IDLE;
         endcase
      end
   end

   // Result is decided at the stop sample so the pulse lands in the RESULT cycle.
   always_comb begin
      data_nxt      = data;
      done_nxt      = 1'b0;
      frame_err_nxt = 1'b0;
      busy_nxt      = (next_state != RX_IDLE);
      if (en && (state == RX_STOP) && sample) begin
         if (err || !rx_s) begin
            frame_err_nxt = 1'b1;
         end else begin
            done_nxt = 1'b1;
            data_nxt = shift;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data      <= '0;
         done      <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         data      <= data_nxt;
         done      <= done_nxt;
         frame_err <= frame_err_nxt;
         busy      <= busy_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         err      <= 1'b0;
         stop_low <= 1'b0;
      end else begin
         if ((next_state != state) || sample || !timed) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         if (state != RX_DATA) begin
            bit_cnt <= '0;
         end else if (sample) begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
         end

         if ((state == RX_DATA) && sample) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
         end

         if (!en || (state == RX_IDLE)) begin
            err <= 1'b0;
         end else if (((state == RX_MARK) || (state == RX_STOP)) && sample && !rx_s) begin
            err <= 1'b1;
         end

         if ((state == RX_STOP) && sample) begin
            stop_low <= !rx_s;
         end
      end
   end

endmodule

// File: tb/tb_zuart_module_rx.sv
// Directed bench for zuart_module_rx: one instance with the mark bit, one without.
module tb_zuart_module_rx;

   localparam int unsigned N = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       rx1 = 1'b1;
   logic       rx0 = 1'b1;
   logic [7:0] data1, data0;
   logic       done1, ferr1, busy1;
   logic       done0, ferr0, busy0;

   always #5 clk = ~clk;

   zuart_module_rx #(.CLKS_PER_BIT(N), .EXTRA_BIT(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .rx_pin(rx1),
      .data(data1), .done(done1), .frame_err(ferr1), .busy(busy1)
   );

   zuart_module_rx #(.CLKS_PER_BIT(N), .EXTRA_BIT(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .rx_pin(rx0),
      .data(data0), .done(done0), .frame_err(ferr0), .busy(busy0)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: counts, timestamps, width and overlap violations.
   int         done_cnt1 = 0, ferr_cnt1 = 0, done_cnt0 = 0, ferr_cnt0 = 0;
   int         done_t1[64], done_t0[64];
   logic [7:0] done_d1[64], done_d0[64];
   logic [7:0] ferr_data1 = 8'h00;
   int         overlap = 0, wide = 0;
   logic       pd1 = 1'b0, pf1 = 1'b0, pd0 = 1'b0, pf0 = 1'b0;

   always @(negedge clk) begin
      if (done1) begin
         if (done_cnt1 < 64) begin
            done_t1[done_cnt1] = cyc;
            done_d1[done_cnt1] = data1;
         end
         done_cnt1++;
      end
      if (ferr1) begin
         ferr_data1 = data1;
         ferr_cnt1++;
      end
      if (done0) begin
         if (done_cnt0 < 64) begin
            done_t0[done_cnt0] = cyc;
            done_d0[done_cnt0] = data0;
         end
         done_cnt0++;
      end
      if (ferr0) ferr_cnt0++;
      if ((done1 && ferr1) || (done0 && ferr0)) overlap++;
      if ((done1 && pd1) || (ferr1 && pf1) || (done0 && pd0) || (ferr0 && pf0)) wide++;
      pd1 = done1;
      pf1 = ferr1;
      pd0 = done0;
      pf0 = ferr0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input bit line0, input int cycles);
      if (line0) rx0 = v;
      else       rx1 = v;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input logic mark, input logic stop,
                       input bit extra, input bit line0);
      drive(1'b0, line0, N);
      for (int i = 0; i < 8; i++) drive(b[i], line0, N);
      if (extra) drive(mark, line0, N);
      drive(stop, line0, N);
   endtask

   // Start bit and data bits 0..3, then stop halfway through data bit 4.
   task automatic send_partial(input logic [7:0] b);
      drive(1'b0, 1'b0, N);
      for (int i = 0; i < 4; i++) drive(b[i], 1'b0, N);
      drive(b[4], 1'b0, N / 2);
   endtask

   int d1b, f1b, d0b, f0b;

   task automatic snap();
      d1b = done_cnt1;
      f1b = ferr_cnt1;
      d0b = done_cnt0;
      f0b = ferr_cnt0;
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      idle(3);
      check("rst_data", 32'(data1), 32'h00);
      check("rst_done", 32'(done1), 32'h0);
      check("rst_ferr", 32'(ferr1), 32'h0);
      check("rst_busy", 32'(busy1), 32'h0);
      rst = 1'b0;
      en  = 1'b1;
      idle(4);

      // 1: good frame
      snap();
      send(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2 * N);
      check("t1_done_cnt", 32'(done_cnt1 - d1b), 32'd1);
      check("t1_ferr_cnt", 32'(ferr_cnt1 - f1b), 32'd0);
      check("t1_data", 32'(data1), 32'hA5);
      check("t1_busy", 32'(busy1), 32'h0);

      // 2: short glitch rejected at mid-bit
      snap();
      rx1 = 1'b0;
      idle(4);
      check("t2_busy_hi", 32'(busy1), 32'h1);
      rx1 = 1'b1;
      idle(8);
      check("t2_busy_lo", 32'(busy1), 32'h0);
      idle(2 * N);
      check("t2_done_cnt", 32'(done_cnt1 - d1b), 32'd0);
      check("t2_ferr_cnt", 32'(ferr_cnt1 - f1b), 32'd0);
      check("t2_data", 32'(data1), 32'hA5);

      // 3: bad stop, line held low, then a good frame
      snap();
      send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 20);
      check("t3_wait_busy", 32'(busy1), 32'h1);
      drive(1'b0, 1'b0, 20);
      rx1 = 1'b1;
      idle(2 * N);
      check("t3_ferr_cnt", 32'(ferr_cnt1 - f1b), 32'd1);
      check("t3_done_cnt", 32'(done_cnt1 - d1b), 32'd0);
      check("t3_data_held", 32'(data1), 32'hA5);
      check("t3_ferr_data", 32'(ferr_data1), 32'hA5);
      check("t3_busy", 32'(busy1), 32'h0);
      snap();
      send(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2 * N);
      check("t3b_done_cnt", 32'(done_cnt1 - d1b), 32'd1);
      check("t3b_ferr_cnt", 32'(ferr_cnt1 - f1b), 32'd0);
      check("t3b_data", 32'(data1), 32'h3C);

      // 4: bad mark bit, then a good frame with no idle gap
      snap();
      send(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      send(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2 * N);
      check("t4_ferr_cnt", 32'(ferr_cnt1 - f1b), 32'd1);
      check("t4_done_cnt", 32'(done_cnt1 - d1b), 32'd1);
      check("t4_ferr_data", 32'(ferr_data1), 32'h3C);
      check("t4_data", 32'(data1), 32'hFF);

      // 5: three back-to-back frames, with and without the mark bit
      snap();
      send(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
      send(8'h80, 1'b1, 1'b1, 1'b1, 1'b0);
      send(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2 * N);
      check("t5_done_cnt", 32'(done_cnt1 - d1b), 32'd3);
      if (d1b + 2 < 64) begin
         check("t5_d0", 32'(done_d1[d1b]), 32'h01);
         check("t5_d1", 32'(done_d1[d1b + 1]), 32'h80);
         check("t5_d2", 32'(done_d1[d1b + 2]), 32'hFF);
         check("t5_gap01", 32'(done_t1[d1b + 1] - done_t1[d1b]), 32'd176);
         check("t5_gap12", 32'(done_t1[d1b + 2] - done_t1[d1b + 1]), 32'd176);
      end
      send(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
      send(8'h80, 1'b1, 1'b1, 1'b0, 1'b1);
      send(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(2 * N);
      check("t5n_done_cnt", 32'(done_cnt0 - d0b), 32'd3);
      check("t5n_ferr_cnt", 32'(ferr_cnt0 - f0b), 32'd0);
      if (d0b + 2 < 64) begin
         check("t5n_d0", 32'(done_d0[d0b]), 32'h01);
         check("t5n_d1", 32'(done_d0[d0b + 1]), 32'h80);
         check("t5n_d2", 32'(done_d0[d0b + 2]), 32'hFF);
         check("t5n_gap01", 32'(done_t0[d0b + 1] - done_t0[d0b]), 32'd160);
         check("t5n_gap12", 32'(done_t0[d0b + 2] - done_t0[d0b + 1]), 32'd160);
      end

      // 6a: reset in the middle of data bit 4
      snap();
      send_partial(8'h5A);
      rst = 1'b1;
      idle(1);
      check("t6_rst_data", 32'(data1), 32'h00);
      check("t6_rst_done", 32'(done1), 32'h0);
      check("t6_rst_ferr", 32'(ferr1), 32'h0);
      check("t6_rst_busy", 32'(busy1), 32'h0);
      idle(2);
      rx1 = 1'b1;
      rst = 1'b0;
      idle(2 * N);
      check("t6_rst_done_cnt", 32'(done_cnt1 - d1b), 32'd0);
      check("t6_rst_ferr_cnt", 32'(ferr_cnt1 - f1b), 32'd0);
      send(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2 * N);
      check("t6_rst_rx_cnt", 32'(done_cnt1 - d1b), 32'd1);
      check("t6_rst_rx_data", 32'(data1), 32'h5A);

      // 6b: enable dropped in the middle of data bit 4
      snap();
      send_partial(8'h5A);
      en = 1'b0;
      idle(2);
      check("t6_en_busy", 32'(busy1), 32'h0);
      rx1 = 1'b1;
      en  = 1'b1;
      idle(2 * N);
      check("t6_en_done_cnt", 32'(done_cnt1 - d1b), 32'd0);
      check("t6_en_ferr_cnt", 32'(ferr_cnt1 - f1b), 32'd0);
      check("t6_en_data", 32'(data1), 32'h5A);
      send(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2 * N);
      check("t6_en_rx_cnt", 32'(done_cnt1 - d1b), 32'd1);
      check("t6_en_rx_data", 32'(data1), 32'h5A);
      check("t6_en_rx_ferr", 32'(ferr_cnt1 - f1b), 32'd0);

      check("overlap", 32'(overlap), 32'd0);
      check("pulse_width", 32'(wide), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/zuart_module_rx.md
Name: zuart_module_rx

Overview:
- UART receiver. Recovers 8-bit bytes from a serial line carrying the team's UART frame: start(0), 8 data bits LSB first, one fixed mark bit (1) in the parity slot, stop(1).
- Sits at the FPGA RX pin, upstream of the command parser.
- Self-timed from the system clock through an internal baud counter. Samples each bit at mid-bit. Reports each byte with a one-cycle `done` pulse, or reports a bad frame with a one-cycle `frame_err` pulse.

Parameters:
- CLKS_PER_BIT, 434, system clocks per bit (50 MHz / 115200). Must be >= 4.
- EXTRA_BIT, 1, 1 = frame carries the mark bit between data and stop; 0 = no mark bit (start, 8 data, stop).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  receiver enable. Low = abort frame and hold idle.
- rx_pin  in  1  asynchronous serial input. Idles high.
- data  out  8  last correctly received byte. Held until the next good frame.
- done  out  1  one-cycle pulse. `data` is valid in the same cycle.
- frame_err  out  1  one-cycle pulse. Mark or stop bit sampled 0.
- busy  out  1  high from start detection until return to IDLE.

Behaviour:
- Reset values: `data`=8'h00, `done`=0, `frame_err`=0, `busy`=0. Synchronizer flops=1. State=IDLE. Counters=0.
- Input sync: rx_pin passes through 2 flops to give rx_s. All decisions use rx_s only.
- Define H = CLKS_PER_BIT/2 (integer division) and N = CLKS_PER_BIT.
- Baud counter width = $clog2(CLKS_PER_BIT). It resets to 0 on every state entry.
- States:
  - IDLE: `busy`=0. rx_s==0 -> START. Call the cycle of detection t=0.
  - START: wait until t=H, then sample. rx_s==1 -> glitch: return to IDLE, no pulse of any kind. rx_s==0 -> DATA.
  - DATA: sample at t=H+(k+1)*N for k=0..7. Right-shift the sample into shift[7], so bit k ends at shift[k]. After k=7 go to MARK if EXTRA_BIT, else STOP.
  - MARK: sample at t=H+9N. A 0 sets an internal err flag.
  - STOP: sample at t=H+(9+EXTRA_BIT)*N. A 0 sets err.
  - RESULT (1 cycle):
    - No err: data<=shift and done=1.
    - err: frame_err=1 and data unchanged.
    - Next state: if stop sampled 0 -> WAIT_HIGH, else IDLE.
  - WAIT_HIGH: `busy`=1. Stay until rx_s==1, then go to IDLE. This prevents a break or stuck-low line from being read as a stream of 0x00 frames.
- Latency: `done`/`frame_err` assert at t=H+(9+EXTRA_BIT)*N+1, plus 2 synchronizer cycles relative to the rx_pin edge.
- `done` and `frame_err` are never high in the same cycle. Each is exactly one cycle wide per frame.
- Back-to-back frames: from IDLE, a new start edge is accepted the cycle after RESULT. No minimum idle gap beyond the stop bit.
- en low, any state: go to IDLE next cycle and clear the err flag. No pulse. `data` is held. The sync flops keep running. If rx_s is already 0 when en rises, it counts as a start and is validated at mid-bit.
- rst mid-frame: all outputs and state return to reset values immediately (asynchronous). Reception restarts only on a later falling edge.

Decomposition:
- Package zuart_pkg:
  - rx state enum (IDLE, START, DATA, MARK, STOP, RESULT, WAIT_HIGH).
  - default CLKS_PER_BIT constant.
  - DATA_BITS=8.
  - The TX side shares the package for its frame constants.
- One natural sub-module: zuart_rx_sync. It is a 2-flop synchronizer, reset to 1 on rst, reusable for other async inputs.
- Baud counter and bit counter stay inline.

Test Plan (CLKS_PER_BIT=16, EXTRA_BIT=1 unless noted):
1. Frame 0xA5, mark=1, stop=1 -> exactly one `done` pulse. `data`=8'hA5. `frame_err` stays 0. `busy` falls after RESULT.
2. rx_pin low for 4 clocks, then high -> no `done`, no `frame_err`. `busy` returns to 0 by t=H+1. `data` unchanged.
3. 0x3C with stop=0, then line held low 40 clocks, then high, then a good 0x3C -> first frame: one `frame_err` pulse, `data` still 8'hA5. No frame is decoded during the low hold. Second frame: `done` and `data`=8'h3C.
4. 0x00 with mark bit=0 -> `frame_err` pulse, no `done`. Then 0xFF back-to-back with zero idle gap -> `done`, `data`=8'hFF.
5. Frames 0x01, 0x80, 0xFF sent back-to-back -> three `done` pulses exactly 11*16 clocks apart with matching `data`. Repeat with EXTRA_BIT=0 -> spacing 10*16 clocks.
6. rst pulsed during data bit 4, and separately en dropped during data bit 4 -> all outputs at reset values / idle with no pulse. A following 0x5A frame is received correctly.
